// File: rtl/iq_readout_seq_if.sv
// Output sample stream between the IQ readout sequencer and its consumer.
// Latency: none, wires only.
// Backpressure: a word transfers when out_valid && out_ready; the source holds out_data while stalled.
// Signals: out_data (16-bit sample word), out_valid (source), out_ready (sink).
interface iq_readout_seq_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/iq_readout_seq.sv
// Sequences an IQ sampler read port and streams count pairs as I0,Q0,I1,Q1,...
// Latency: first word valid 5 cycles after an accepted start (SYNC, PRIME, CAP_I, CAP_Q, then registered out).
// Backpressure: out_ready low holds the current word stable; sampler reads pause until the pair drains.
// Ports: rd_clk/rd_rst_n clock and async active-low reset; start/abort/count/offset control;
//        rd_sync/rd_i/rd_q/rd_offset/rd_iq sampler read port; stream output words; busy/done status.
module iq_readout_seq #(
  parameter int CNT_W = 13
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [11:0]      offset,
  output logic             rd_sync,
  output logic             rd_i,
  output logic             rd_q,
  output logic [11:0]      rd_offset,
  input  logic [15:0]      rd_iq,
  iq_readout_seq_if.master stream,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, SYNC, PRIME, CAP_I, CAP_Q, EMIT_I, EMIT_Q, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remain;
  logic [11:0]      offset_q;
  logic [15:0]      i_hold, q_hold;
  logic [15:0]      out_data_q;
  logic             out_valid_q;

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = (count != '0) ? SYNC : FIN;
      SYNC:   state_nxt = PRIME;
      PRIME:  state_nxt = CAP_I;
      CAP_I:  state_nxt = CAP_Q;
      CAP_Q:  state_nxt = EMIT_I;
      EMIT_I: if (stream.out_ready) state_nxt = EMIT_Q;
      EMIT_Q: if (stream.out_ready) state_nxt = (remain != '0) ? CAP_I : FIN;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Datapath. The sampler presents a registered {I,Q} pair one cycle after the
  // address moves, and rd_i muxes the half, so I and Q of one address are read
  // in back-to-back CAP cycles; rd_q then advances the address for the next pair.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      remain      <= '0;
      offset_q    <= '0;
      i_hold      <= '0;
      q_hold      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state == IDLE && start && count != '0) begin
        remain   <= count;
        offset_q <= offset;
      end
      if (state == CAP_I) i_hold <= rd_iq;
      if (state == CAP_Q) begin
        q_hold <= rd_iq;
        remain <= remain - CNT_W'(1);
      end
      // Load the output word only on entry to an EMIT state so it holds while stalled.
      if (state != EMIT_I && state_nxt == EMIT_I) out_data_q <= i_hold;
      if (state == EMIT_I && state_nxt == EMIT_Q) out_data_q <= q_hold;
      out_valid_q <= (state_nxt == EMIT_I) || (state_nxt == EMIT_Q);
    end
  end

  assign rd_sync          = (state == SYNC);
  assign rd_i             = (state == CAP_I);
  assign rd_q             = (state == CAP_Q);
  assign rd_offset        = offset_q;
  assign busy             = (state != IDLE);
  assign done             = (state == FIN);
  assign stream.out_data  = out_data_q;
  assign stream.out_valid = out_valid_q;

endmodule

// File: doc/iq_readout_seq.md
IQ_READOUT_SEQ -- requirements
Module: iq_readout_seq

Interface
REQ-001 Parameter: CNT_W, 13, width of pair-count input; 4096 IQ pairs maximum.
REQ-002 Single clock domain (rd_clk); reset is asynchronous and active-low (rd_rst_n).
REQ-003 rd_clk  input  1  read-side clock, shared with the IQ sampler read port.
REQ-004 rd_rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a readout; ignored unless IDLE.
REQ-006 abort  input  1  terminate the readout in progress, return to IDLE.
REQ-007 count  input  CNT_W  number of IQ pairs to read, sampled on accepted start.
REQ-008 offset  input  12  look-ahead offset, sampled on accepted start, driven to the sampler as rd_offset.
REQ-009 rd_sync  output  1  sampler address resync strobe.
REQ-010 rd_i  output  1  sampler half-select: 1 selects I, 0 selects Q.
REQ-011 rd_q  output  1  sampler read-address advance strobe.
REQ-012 rd_offset  output  12  registered copy of offset.
REQ-013 rd_iq  input  16  sampler read data, valid one cycle after the address is presented.
REQ-014 out_data  output  16  streamed sample word.
REQ-015 out_valid  output  1  out_data is valid.
REQ-016 out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when a readout completes normally.

Function
REQ-019 States SHALL be IDLE, SYNC, PRIME, CAP_I, CAP_Q, EMIT_I, EMIT_Q, FIN.
REQ-020 IDLE + start with count!=0: latch count and offset, go to SYNC.
- IDLE + start with count==0: go to FIN, with no sampler strobes.
REQ-021 rd_sync SHALL be 1 only in SYNC, for exactly one cycle; the next state is PRIME.
REQ-022 PRIME SHALL last one cycle with rd_q=0, covering BRAM latency; the next state is CAP_I.
REQ-023 CAP_I: rd_i=1, rd_q=0; capture rd_iq into the I holding register; go to CAP_Q.
REQ-024 CAP_Q: rd_i=0, rd_q=1; capture rd_iq into the Q holding register; decrement the remaining count; go to EMIT_I.
REQ-025 rd_q SHALL be 1 only in CAP_Q.
REQ-026 rd_i SHALL be 1 only in CAP_I.
REQ-027 EMIT_I: out_data=I, out_valid=1; hold until out_ready, then go to EMIT_Q.
REQ-028 EMIT_Q: out_data=Q, out_valid=1; on out_ready go to CAP_I if the remaining count is nonzero, else go to FIN.
REQ-029 out_data and out_valid SHALL be registered, and out_data SHALL stay stable while out_valid && !out_ready.
REQ-030 Word order SHALL be I0,Q0,I1,Q1,...; total words = 2*count.
REQ-031 Sample k SHALL come from sampler address (sync_wr_addr+offset+k) mod 2^13, wrapping freely.
REQ-032 FIN SHALL assert done for one cycle, then go to IDLE.
REQ-033 abort SHALL take priority over all transitions in any non-IDLE state.
- Next state is IDLE; out_valid=0; no done pulse.
- A word presented in the abort cycle is not considered transferred.
REQ-034 abort and start in the same cycle in IDLE: start wins.
REQ-035 start while busy SHALL be ignored, with no change to the latched count or offset.
REQ-036 count=4096 SHALL be accepted; the remaining-count register is CNT_W wide.

Reset
REQ-037 rd_rst_n=0 SHALL asynchronously force state IDLE and clear all registers.
- rd_sync=0, rd_i=0, rd_q=0, rd_offset=0.
- out_data=0, out_valid=0, busy=0, done=0.
REQ-038 Reset asserted mid-readout SHALL discard the readout with no done pulse.
REQ-039 Release of rd_rst_n SHALL take effect on a rd_clk edge, with no output glitch.

Verification
REQ-040 Setup: sampler memory preloaded with I=addr, Q=~addr, sync_wr_addr=100, offset=5.
- Stimulus: start, count=3, out_ready=1.
- Response: words 105,~105,106,~106,107,~107; done 1 cycle after the last transfer.
REQ-041 Same setup, out_ready toggling 1-0-1 randomly.
- Response: identical word sequence.
- out_data is stable during stall cycles.
- rd_q pulses exactly 3 times.
REQ-042 Stimulus: sync_wr_addr=8190, offset=4095, count=4.
- Response: addresses 4093,4094,4095,4096 read in order; no error at the modulo-8192 boundary.
REQ-043 Stimulus: start with count=0.
- Response: busy for 1 cycle, done pulse, no rd_sync, no out_valid.
REQ-044 Stimulus: abort during EMIT_Q of pair 1 with count=4.
- Response: IDLE next cycle, out_valid=0, no done.
- A following start with count=1 streams correctly.
REQ-045 Stimulus: rd_rst_n pulsed low mid-CAP_Q.
- Response: all outputs 0 immediately; next start behaves as from power-up.
